regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter_pkg.sv | 16 +
 rtl/regfile_write_arbiter_if.sv | 43 ++++
 rtl/regfile_write_arbiter_arb2_pick.sv | 31 +++
 rtl/regfile_write_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_pkg: shared defaults and state encoding for regfile_write_arbiter.
//   ADDR_W, DATA_W, NUM_REGS, CLEAR_VALUE : default geometry and clear pattern
//   arbState_t                            : CLEAR (clear pass) / RUN (arbitration)
package regfile_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam logic [31:0] CLEAR_VALUE = 32'h0000_0000;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arbState_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: request/grant bus for the two write requesters,
// the clear-pass control and the register-file write port.
//   Req0/Addr0/Data0/Gnt0 : port 0 (CPU writeback)
//   Req1/Addr1/Data1/Gnt1 : port 1 (host/debug loader)
//   ClearReq/Busy         : clear-pass start pulse and in-progress flag
//   WriteRegister/WriteData/RegWrite : register-file write port
// Modports: master = requesters and register file, slave = arbiter.
interface regfile_write_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);

    logic              Req0;
    logic [ADDR_W-1:0] Addr0;
    logic [DATA_W-1:0] Data0;
    logic              Gnt0;
    logic              Req1;
    logic [ADDR_W-1:0] Addr1;
    logic [DATA_W-1:0] Data1;
    logic              Gnt1;
    logic              ClearReq;
    logic              Busy;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;

    modport master (
        output Req0, Addr0, Data0,
        output Req1, Addr1, Data1,
        output ClearReq,
        input  Gnt0, Gnt1, Busy,
        input  WriteRegister, WriteData, RegWrite
    );

    modport slave (
        input  Req0, Addr0, Data0,
        input  Req1, Addr1, Data1,
        input  ClearReq,
        output Gnt0, Gnt1, Busy,
        output WriteRegister, WriteData, RegWrite
    );

endinterface

// File: rtl/regfile_write_arbiter_arb2_pick.sv
// arb2_pick: combinational two-input grant picker.
//   Req0, Req1 : requests
//   LastGnt    : port granted on the last completed handshake (1 = port 1)
//   Gnt0, Gnt1 : one-hot (or zero) grants
// Macro REGFILE_ARB_ROUND_ROBIN_EN selects round-robin on contention;
// otherwise port 0 always wins and LastGnt is ignored.
module arb2_pick (
    input  logic Req0,
    input  logic Req1,
    input  logic LastGnt,
    output logic Gnt0,
    output logic Gnt1
);

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    // On contention the port that did not win last time goes first.
    always_comb begin
        Gnt0 = Req0 & (~Req1 | LastGnt);
        Gnt1 = Req1 & (~Req0 | ~LastGnt);
    end
`else
    logic unusedLastGnt;
    assign unusedLastGnt = LastGnt;

    always_comb begin
        Gnt0 = Req0;
        Gnt1 = Req1 & ~Req0;
    end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port between
// port 0 (CPU writeback) and port 1 (host/debug loader), and runs a clear
// pass writing CLEAR_VALUE to every register after reset or on ClearReq.
//   Clk   : clock, all state on posedge
//   Rst_n : asynchronous active-low reset
//   bus   : regfile_write_arbiter_if.slave (requests, grants, ClearReq/Busy,
//           registered WriteRegister/WriteData/RegWrite)
// Macro REGFILE_ARB_ROUND_ROBIN_EN adds the LastGnt flop for round-robin
// arbitration; undefined gives fixed priority, port 0 first.
module regfile_write_arbiter #(
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(regfile_pkg::CLEAR_VALUE)
) (
    input logic Clk,
    input logic Rst_n,
    regfile_write_arbiter_if.slave bus
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    arbState_t         state;
    logic [ADDR_W-1:0] clrIdx;
    logic [ADDR_W-1:0] writeRegisterQ;
    logic [DATA_W-1:0] writeDataQ;
    logic              regWriteQ;

    logic              lastGnt;
    logic              pickGnt0;
    logic              pickGnt1;
    logic              runOpen;
    logic              gnt0;
    logic              gnt1;
    logic              hs0;
    logic              hs1;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

    arb2_pick uPick (
        .Req0    (bus.Req0),
        .Req1    (bus.Req1),
        .LastGnt (lastGnt),
        .Gnt0    (pickGnt0),
        .Gnt1    (pickGnt1)
    );

    // Grants are only open in RUN and are suppressed in a ClearReq cycle so
    // the clear request can never coincide with a handshake.
    always_comb begin
        runOpen = (state == RUN) && !bus.ClearReq;
        gnt0    = runOpen & pickGnt0;
        gnt1    = runOpen & pickGnt1;
        hs0     = bus.Req0 & gnt0;
        hs1     = bus.Req1 & gnt1;
        selAddr = hs0 ? bus.Addr0 : bus.Addr1;
        selData = hs0 ? bus.Data0 : bus.Data1;
    end

    assign bus.Gnt0          = gnt0;
    assign bus.Gnt1          = gnt1;
    assign bus.Busy          = (state == CLEAR);
    assign bus.WriteRegister = writeRegisterQ;
    assign bus.WriteData     = writeDataQ;
    assign bus.RegWrite      = regWriteQ;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state          <= CLEAR;
            clrIdx         <= '0;
            writeRegisterQ <= '0;
            writeDataQ     <= '0;
            regWriteQ      <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    regWriteQ      <= 1'b1;
                    writeRegisterQ <= clrIdx;
                    writeDataQ     <= CLEAR_VALUE;
                    if (clrIdx == LAST_IDX) begin
                        clrIdx <= '0;
                        state  <= RUN;
                    end else begin
                        clrIdx <= clrIdx + ADDR_W'(1);
                    end
                end
                RUN: begin
                    if (bus.ClearReq) begin
                        regWriteQ <= 1'b0;
                        clrIdx    <= '0;
                        state     <= CLEAR;
                    end else if (hs0 || hs1) begin
                        // Register 0 handshakes are accepted but dropped,
                        // leaving the previous address/data on the port.
                        if (selAddr != '0) begin
                            regWriteQ      <= 1'b1;
                            writeRegisterQ <= selAddr;
                            writeDataQ     <= selData;
                        end else begin
                            regWriteQ <= 1'b0;
                        end
                    end else begin
                        regWriteQ <= 1'b0;
                    end
                end
                default: begin
                    state     <= CLEAR;
                    clrIdx    <= '0;
                    regWriteQ <= 1'b0;
                end
            endcase
        end
    end

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    // Reset value 1 means "port 1 won last", giving port 0 first priority.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lastGnt <= 1'b1;
        end else if (hs0) begin
            lastGnt <= 1'b0;
        end else if (hs1) begin
            lastGnt <= 1'b1;
        end
    end
`else
    assign lastGnt = 1'b1;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed bench for regfile_write_arbiter.
// Honours REGFILE_ARB_ROUND_ROBIN_EN for the contention expectations.
module tb_regfile_write_arbiter;

    logic Clk;
    logic Rst_n;
    int   checks;
    int   failures;

    regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_write_arbiter #(
        .NUM_REGS    (32),
        .ADDR_W      (5),
        .DATA_W      (32),
        .CLEAR_VALUE (32'h0000_0000)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [31:0] expAddr;
    logic [31:0] expData;
    logic        expG0;

    initial begin
        checks   = 0;
        failures = 0;
        Rst_n        = 1'b0;
        bus.Req0     = 1'b0;
        bus.Addr0    = '0;
        bus.Data0    = '0;
        bus.Req1     = 1'b1;
        bus.Addr1    = 5'd3;
        bus.Data1    = 32'h1111_2222;
        bus.ClearReq = 1'b0;

        // Reset state
        #3;
        checkVal("rst_regwrite", 32'(bus.RegWrite), 32'd0);
        checkVal("rst_wreg", 32'(bus.WriteRegister), 32'd0);
        checkVal("rst_wdata", bus.WriteData, 32'd0);
        checkVal("rst_busy", 32'(bus.Busy), 32'd1);
        checkVal("rst_gnt0", 32'(bus.Gnt0), 32'd0);
        checkVal("rst_gnt1", 32'(bus.Gnt1), 32'd0);

        // 1: clear pass after reset release, Req1 held throughout
        tick();
        Rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            checkVal("clr_regwrite", 32'(bus.RegWrite), 32'd1);
            checkVal("clr_wreg", 32'(bus.WriteRegister), 32'(i));
            checkVal("clr_wdata", bus.WriteData, 32'd0);
            checkVal("clr_busy", 32'(bus.Busy), (i == 31) ? 32'd0 : 32'd1);
            checkVal("clr_gnt1", 32'(bus.Gnt1), (i == 31) ? 32'd1 : 32'd0);
        end
        bus.Req1 = 1'b0;
        tick();
        checkVal("idle_regwrite", 32'(bus.RegWrite), 32'd0);

        // 3: contention for 4 cycles
        bus.Req0  = 1'b1;
        bus.Addr0 = 5'd7;
        bus.Data0 = 32'hA0A0_A0A0;
        bus.Req1  = 1'b1;
        bus.Addr1 = 5'd9;
        bus.Data1 = 32'hB1B1_B1B1;
        for (int k = 0; k < 4; k++) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            expG0 = (k % 2 == 0);
`else
            expG0 = 1'b1;
`endif
            #1;
            checkVal("cont_gnt0", 32'(bus.Gnt0), 32'(expG0));
            checkVal("cont_gnt1", 32'(bus.Gnt1), 32'(!expG0));
            expAddr = expG0 ? 32'd7 : 32'd9;
            expData = expG0 ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1;
            tick();
            checkVal("cont_regwrite", 32'(bus.RegWrite), 32'd1);
            checkVal("cont_wreg", 32'(bus.WriteRegister), expAddr);
            checkVal("cont_wdata", bus.WriteData, expData);
        end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;

        // 2: single port 0 write
        tick();
        bus.Req0  = 1'b1;
        bus.Addr0 = 5'd5;
        bus.Data0 = 32'hDEAD_BEEF;
        #1;
        checkVal("p0_gnt0", 32'(bus.Gnt0), 32'd1);
        checkVal("p0_gnt1", 32'(bus.Gnt1), 32'd0);
        tick();
        bus.Req0 = 1'b0;
        checkVal("p0_regwrite", 32'(bus.RegWrite), 32'd1);
        checkVal("p0_wreg", 32'(bus.WriteRegister), 32'd5);
        checkVal("p0_wdata", bus.WriteData, 32'hDEAD_BEEF);
        tick();
        checkVal("p0_after_regwrite", 32'(bus.RegWrite), 32'd0);
        checkVal("p0_hold_wreg", 32'(bus.WriteRegister), 32'd5);
        checkVal("p0_hold_wdata", bus.WriteData, 32'hDEAD_BEEF);

        // 4: port 1 write to register 0 is accepted but dropped
        bus.Req1  = 1'b1;
        bus.Addr1 = 5'd0;
        bus.Data1 = 32'h5555_5555;
        #1;
        checkVal("r0_gnt1", 32'(bus.Gnt1), 32'd1);
        tick();
        bus.Req1 = 1'b0;
        checkVal("r0_regwrite", 32'(bus.RegWrite), 32'd0);

        // 5: ClearReq while Req0 held
        bus.Req0     = 1'b1;
        bus.Addr0    = 5'd12;
        bus.Data0    = 32'hC0DE_0012;
        bus.ClearReq = 1'b1;
        #1;
        checkVal("cr_gnt0", 32'(bus.Gnt0), 32'd0);
        checkVal("cr_busy", 32'(bus.Busy), 32'd0);
        tick();
        bus.ClearReq = 1'b0;
        checkVal("cr_regwrite", 32'(bus.RegWrite), 32'd0);
        checkVal("cr_busy_after", 32'(bus.Busy), 32'd1);
        checkVal("cr_gnt0_clear", 32'(bus.Gnt0), 32'd0);
        for (int i = 0; i < 32; i++) begin
            tick();
            checkVal("cr_clr_regwrite", 32'(bus.RegWrite), 32'd1);
            checkVal("cr_clr_wreg", 32'(bus.WriteRegister), 32'(i));
            checkVal("cr_clr_wdata", bus.WriteData, 32'd0);
            checkVal("cr_clr_gnt0", 32'(bus.Gnt0), (i == 31) ? 32'd1 : 32'd0);
        end
        tick();
        bus.Req0 = 1'b0;
        checkVal("cr_post_regwrite", 32'(bus.RegWrite), 32'd1);
        checkVal("cr_post_wreg", 32'(bus.WriteRegister), 32'd12);
        checkVal("cr_post_wdata", bus.WriteData, 32'hC0DE_0012);

        // 6: reset in the middle of a clear pass
        bus.ClearReq = 1'b1;
        tick();
        bus.ClearReq = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
        end
        checkVal("mid_wreg17", 32'(bus.WriteRegister), 32'd17);
        Rst_n = 1'b0;
        #1;
        checkVal("mid_rst_regwrite", 32'(bus.RegWrite), 32'd0);
        checkVal("mid_rst_wreg", 32'(bus.WriteRegister), 32'd0);
        checkVal("mid_rst_busy", 32'(bus.Busy), 32'd1);
        #3;
        Rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            checkVal("rs_clr_wreg", 32'(bus.WriteRegister), 32'(i));
            checkVal("rs_clr_regwrite", 32'(bus.RegWrite), 32'd1);
        end
        checkVal("rs_busy_done", 32'(bus.Busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
